// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO and sequencer.
// Provides the byte width and the one-hot sequencer state encoding.
package uart_tx_fifo_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_PULSE = 5'b00010,
        S_WAITB = 5'b00100,
        S_SEND  = 5'b01000,
        S_GAP   = 5'b10000
    } state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO: circular storage, pointers, occupancy, full/empty and
// sticky overflow flag.
// Ports: clk, rst (async, active-high); wr_data_i/wr_en_i enqueue;
// rd_en_i pops the head shown on rd_data_o; full_o, empty_o, count_o
// report fill level; ovf_o is sticky and is cleared by ovf_clr_i.
module uart_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   wr_data_i,
    input  logic                wr_en_i,
    input  logic                rd_en_i,
    input  logic                ovf_clr_i,
    output logic [BYTE_W-1:0]   rd_data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                ovf_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [BYTE_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, empty_q;
    logic                  ovf_q, ovf_d;
    logic                  do_rd, do_wr, drop;

    always_comb begin
        do_rd = rd_en_i && !empty_q;
        // A pop in the same cycle frees a slot, so a write at full is legal.
        do_wr = wr_en_i && (!full_q || do_rd);
        drop  = wr_en_i && full_q && !do_rd;

        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end

        // A dropped write outranks a clear in the same cycle.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus ready/busy handshake sequencer feeding a UART transmitter.
// Ports: clk, rst (async, active-high); wr_data/wr_en enqueue; full, empty,
// count, ovf/ovf_clr report the FIFO; tx_data_o/tx_ready_o/tx_busy_i talk
// to the UART; idle is high when nothing is queued or in flight.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   wr_data,
    input  logic                wr_en,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                ovf,
    input  logic                ovf_clr,
    output logic [BYTE_W-1:0]   tx_data_o,
    output logic                tx_ready_o,
    input  logic                tx_busy_i,
    output logic                idle
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    // Counter starts at 0 on the first wait cycle, so the last wait
    // cycle holds BUSY_TIMEOUT-1 and the re-pulse follows directly.
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [BYTE_W-1:0] head;
    logic              pop;

    uart_sync_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data_i(wr_data),
        .wr_en_i  (wr_en),
        .rd_en_i  (pop),
        .ovf_clr_i(ovf_clr),
        .rd_data_o(head),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (count),
        .ovf_o    (ovf)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Data only ever changes here; the UART resamples it
                // throughout the frame.
                if (!empty) begin
                    pop     = 1'b1;
                    data_d  = head;
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                tmo_d   = '0;
                state_d = S_WAITB;
            end
            S_WAITB: begin
                if (tx_busy_i) begin
                    state_d = S_SEND;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_PULSE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_SEND: begin
                if (!tx_busy_i) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
        end
    end

    assign tx_data_o  = data_q;
    assign tx_ready_o = (state_q == S_PULSE);
    assign idle       = empty && (state_q == S_IDLE);

endmodule
